// File: rtl/glb_pkg.sv
// Shared types and defaults for the global-buffer load path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package glb_pkg;

  // Elements packed into one off-chip FIFO word.
  localparam int PACK              = 4;
  localparam int FIFO_WIDTH_DEF    = 64;
  localparam int DATA_WIDTH_DEF    = FIFO_WIDTH_DEF / PACK;

  // Buffer depths in elements.
  localparam int DEPTH_IFMAP_DEF   = 64896;
  localparam int DEPTH_FILTER_DEF  = 884736;
  localparam int DEPTH_BIAS_DEF    = 384;

  typedef enum logic [1:0] {
    TGT_IFMAP,
    TGT_FILTER,
    TGT_BIAS,
    TGT_ILLEGAL
  } glb_tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } glb_state_e;

endpackage

// File: rtl/glb_load_ctrl.sv
// Command-driven loader: pops FIFO words and writes them into the ifmap/filter/bias GLB port A.
// Latency: FIFO head to GLB write strobe is combinational; address/state update on the next edge.
// Backpressure: fifo_empty stalls the load with no write; cmd_ready is high only in IDLE.
module glb_load_ctrl
  import glb_pkg::*;
#(
  parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH_ifmap  = DEPTH_IFMAP_DEF,
  parameter int DEPTH_filter = DEPTH_FILTER_DEF,
  parameter int DEPTH_bias   = DEPTH_BIAS_DEF,
  localparam int ADDR_ifmap  = $clog2(DEPTH_ifmap),
  localparam int ADDR_filter = $clog2(DEPTH_filter),
  localparam int ADDR_bias   = $clog2(DEPTH_bias)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_target,
  input  logic [ADDR_filter-1:0] cmd_base,
  input  logic [ADDR_filter-1:0] cmd_words,
  input  logic                   fifo_empty,
  input  logic [FIFO_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_re,
  output logic                   we_a_ifmap,
  output logic [ADDR_ifmap-1:0]  addr_a_ifmap,
  output logic [FIFO_WIDTH-1:0]  wdata_a_ifmap,
  output logic                   we_a_filter,
  output logic [ADDR_filter-1:0] addr_a_filter,
  output logic [FIFO_WIDTH-1:0]  wdata_a_filter,
  output logic                   we_a_bias,
  output logic [ADDR_bias-1:0]   addr_a_bias,
  output logic [FIFO_WIDTH-1:0]  wdata_a_bias,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int PACK_L = FIFO_WIDTH / DATA_WIDTH;
  // One extra bit so addr+PACK never overflows before the wrap compare.
  localparam int AW     = ADDR_filter + 1;

  glb_state_e             state, state_nxt;
  glb_tgt_e               tgt, tgt_nxt;
  logic [ADDR_filter-1:0] addr, addr_nxt;
  logic [ADDR_filter-1:0] remaining, rem_nxt;
  logic                   err_nxt;
  logic                   cmd_bad;
  logic [AW-1:0]          addr_inc;
  logic [AW-1:0]          depth_sel;

  // State and datapath registers; reset abandons any in-flight load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tgt       <= TGT_IFMAP;
      addr      <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      err       <= err_nxt;
    end
  end

  // Next write address candidate and the depth of the buffer being filled.
  always_comb begin
    addr_inc  = {1'b0, addr} + AW'(PACK_L);
    depth_sel = AW'(DEPTH_filter);
    case (tgt)
      TGT_IFMAP: depth_sel = AW'(DEPTH_ifmap);
      TGT_BIAS:  depth_sel = AW'(DEPTH_bias);
      default:   depth_sel = AW'(DEPTH_filter);
    endcase
  end

  // Command rejected when the target is illegal or the base is not word-aligned.
  always_comb begin
    cmd_bad = (cmd_target == 2'(TGT_ILLEGAL)) ||
              ((cmd_base % ADDR_filter'(PACK_L)) != '0);
  end

  // FSM next state, counters and handshake outputs.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    addr_nxt  = addr;
    rem_nxt   = remaining;
    err_nxt   = err;
    cmd_ready = 1'b0;
    fifo_re   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          tgt_nxt  = glb_tgt_e'(cmd_target);
          addr_nxt = cmd_base;
          rem_nxt  = cmd_words;
          err_nxt  = cmd_bad;
          if (cmd_bad || (cmd_words == '0)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        fifo_re = !fifo_empty;
        if (!fifo_empty) begin
          addr_nxt = (addr_inc >= depth_sel) ? '0 : addr_inc[ADDR_filter-1:0];
          rem_nxt  = remaining - ADDR_filter'(1);
          if (remaining == ADDR_filter'(1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write demux: only the latched target sees the FIFO head; the others stay at zero.
  always_comb begin
    we_a_ifmap     = 1'b0;
    addr_a_ifmap   = '0;
    wdata_a_ifmap  = '0;
    we_a_filter    = 1'b0;
    addr_a_filter  = '0;
    wdata_a_filter = '0;
    we_a_bias      = 1'b0;
    addr_a_bias    = '0;
    wdata_a_bias   = '0;
    if (state == ST_LOAD) begin
      case (tgt)
        TGT_IFMAP: begin
          we_a_ifmap    = fifo_re;
          addr_a_ifmap  = addr[ADDR_ifmap-1:0];
          wdata_a_ifmap = fifo_rdata;
        end
        TGT_FILTER: begin
          we_a_filter    = fifo_re;
          addr_a_filter  = addr;
          wdata_a_filter = fifo_rdata;
        end
        TGT_BIAS: begin
          we_a_bias    = fifo_re;
          addr_a_bias  = addr[ADDR_bias-1:0];
          wdata_a_bias = fifo_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_load_ctrl.sv
// Bench for glb_load_ctrl: directed scenarios plus randomized commands against a FIFO/address model.
// Latency: writes expected in the same cycle as a non-empty FIFO head during a load.
// Backpressure: FIFO stalls injected by gap counts and random empty cycles.
module tb_glb_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_target;
  logic [19:0] cmd_base;
  logic [19:0] cmd_words;
  logic        fifo_empty;
  logic [63:0] fifo_rdata;
  logic        fifo_re;
  logic        we_a_ifmap;
  logic [15:0] addr_a_ifmap;
  logic [63:0] wdata_a_ifmap;
  logic        we_a_filter;
  logic [19:0] addr_a_filter;
  logic [63:0] wdata_a_filter;
  logic        we_a_bias;
  logic [8:0]  addr_a_bias;
  logic [63:0] wdata_a_bias;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] fifo_q[$];
  logic        err_exp;

  glb_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_base(cmd_base), .cmd_words(cmd_words),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_re(fifo_re),
    .we_a_ifmap(we_a_ifmap), .addr_a_ifmap(addr_a_ifmap), .wdata_a_ifmap(wdata_a_ifmap),
    .we_a_filter(we_a_filter), .addr_a_filter(addr_a_filter), .wdata_a_filter(wdata_a_filter),
    .we_a_bias(we_a_bias), .addr_a_bias(addr_a_bias), .wdata_a_bias(wdata_a_bias),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int depth_of(input int t);
    case (t)
      0:       return 64896;
      1:       return 884736;
      default: return 384;
    endcase
  endfunction

  function automatic logic port_we(input int k);
    case (k)
      0:       return we_a_ifmap;
      1:       return we_a_filter;
      default: return we_a_bias;
    endcase
  endfunction

  function automatic logic [63:0] port_addr(input int k);
    case (k)
      0:       return 64'(addr_a_ifmap);
      1:       return 64'(addr_a_filter);
      default: return 64'(addr_a_bias);
    endcase
  endfunction

  function automatic logic [63:0] port_wdata(input int k);
    case (k)
      0:       return wdata_a_ifmap;
      1:       return wdata_a_filter;
      default: return wdata_a_bias;
    endcase
  endfunction

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back({$urandom(), $urandom()});
  endtask

  task automatic idle_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
  endtask

  task automatic check_quiet(input string tag);
    for (int k = 0; k < 3; k++) chk($sformatf("%s_we%0d", tag, k), 64'(port_we(k)), 64'd0);
    chk({tag, "_re"}, 64'(fifo_re), 64'd0);
  endtask

  // Issue one command at an IDLE cycle and follow it until the controller is back in IDLE.
  task automatic run_cmd(input int t, input int base, input int words, input int gap,
                         input int stall_pct, input bit keep_valid, input int abort_after);
    bit   illegal;
    bit   stall;
    int   pops;
    int   gapc;
    int   budget;
    int   depth;
    illegal = (t == 3) || ((base % 4) != 0);
    depth   = depth_of(t);
    cmd_valid  = 1'b1;
    cmd_target = 2'(t);
    cmd_base   = 20'(base);
    cmd_words  = 20'(words);
    idle_fifo();
    #3;
    chk("acc_rdy", 64'(cmd_ready), 64'd1);
    chk("acc_busy", 64'(busy), 64'd0);
    chk("acc_err", 64'(err), 64'(err_exp));
    check_quiet("acc");
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    err_exp = illegal;
    if (!illegal && words != 0) begin
      pops   = 0;
      gapc   = 0;
      budget = 50 + words * (gap + 1) * 20;
      while (pops < words && budget > 0) begin
        stall = (fifo_q.size() == 0) || (gapc > 0) || ($urandom_range(0, 99) < stall_pct);
        fifo_empty = stall;
        fifo_rdata = stall ? {$urandom(), $urandom()} : fifo_q[0];
        #3;
        chk("ld_busy", 64'(busy), 64'd1);
        chk("ld_done", 64'(done), 64'd0);
        chk("ld_rdy", 64'(cmd_ready), 64'd0);
        chk("ld_err", 64'(err), 64'd0);
        chk("ld_re", 64'(fifo_re), 64'(!stall));
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("ld_we%0d", k), 64'(port_we(k)), 64'((k == t) && !stall));
          if (k != t) begin
            chk($sformatf("ld_addr%0d_idle", k), port_addr(k), 64'd0);
            chk($sformatf("ld_wdata%0d_idle", k), port_wdata(k), 64'd0);
          end else if (!stall) begin
            chk($sformatf("ld_addr%0d", k), port_addr(k), 64'((base + 4 * pops) % depth));
            chk($sformatf("ld_wdata%0d", k), port_wdata(k), fifo_q[0]);
          end
        end
        @(posedge clk); #1;
        budget--;
        if (!stall) begin
          void'(fifo_q.pop_front());
          pops++;
          gapc = gap;
          if (pops == abort_after) return;
        end else if (gapc > 0) begin
          gapc--;
        end
      end
      if (pops < words) chk("ld_timeout_pops", 64'(pops), 64'(words));
    end
    idle_fifo();
    #3;
    chk("dn_done", 64'(done), 64'd1);
    chk("dn_busy", 64'(busy), 64'd1);
    chk("dn_rdy", 64'(cmd_ready), 64'd0);
    chk("dn_err", 64'(err), 64'(err_exp));
    check_quiet("dn");
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_base   = '0;
    cmd_words  = '0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    err_exp    = 1'b0;
    #12;
    chk("rst_rdy", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    check_quiet("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a load, then resume from a fresh base with the remaining words.
    push_words(10);
    run_cmd(0, 40, 10, 0, 0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rdy", 64'(cmd_ready), 64'd1);
    check_quiet("mid_rst");
    @(posedge clk); #1;
    chk("mid_rst_busy2", 64'(busy), 64'd0);
    chk("mid_rst_rdy2", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    err_exp = 1'b0;
    run_cmd(0, 1000, 7, 0, 0, 1'b0, 0);

    // Plain ifmap load of four words.
    push_words(4);
    run_cmd(0, 0, 4, 0, 0, 1'b0, 0);

    // Filter load with two empty cycles between words.
    push_words(3);
    run_cmd(1, 100, 3, 2, 0, 1'b0, 0);

    // Bias load wrapping at the buffer end.
    push_words(3);
    run_cmd(2, 376, 3, 0, 0, 1'b0, 0);

    // Illegal target and misaligned base with data waiting; then a legal cmd and a zero-length cmd.
    push_words(2);
    run_cmd(3, 0, 4, 0, 0, 1'b0, 0);
    run_cmd(0, 6, 4, 0, 0, 1'b0, 0);
    run_cmd(1, 884728, 2, 0, 0, 1'b0, 0);
    run_cmd(2, 8, 0, 0, 0, 1'b0, 0);

    // cmd_valid held through done: back-to-back commands.
    push_words(5);
    run_cmd(0, 500, 2, 0, 0, 1'b1, 0);
    run_cmd(1, 2000, 3, 0, 0, 1'b0, 0);

    // Randomized commands with random FIFO stalls.
    for (int n = 0; n < 24; n++) begin
      int t;
      int w;
      int b;
      t = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      w = $urandom_range(0, 10);
      b = 4 * $urandom_range(0, depth_of(t == 3 ? 0 : t) / 4 - 1);
      if ($urandom_range(0, 3) == 0) b = depth_of(t == 3 ? 0 : t) - 4 * $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) b = b + 2;
      if (t == 3 || (b % 4) != 0) push_words(1);
      else push_words(w);
      run_cmd(t, b, w, $urandom_range(0, 1), 30, 1'b0, 0);
      if (t == 3 || (b % 4) != 0) void'(fifo_q.pop_front());
    end

    idle_fifo();
    #3;
    chk("end_rdy", 64'(cmd_ready), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_err", 64'(err), 64'(err_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
